cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Collects single-cycle result broadcasts from every functional-unit reservation station (ALU, CMP, load/store), buffers one pending result per source, and drives the registered common data bus lanes consumed by the ROB and all reservation stations. It is the receive end of the reservation-station result interface and the transmit end of the CDB. Up to `NUM_LANES` results are broadcast per cycle; selection among pending sources is round-robin so no source starves.

## Interface
- `NUM_SRC`, 8: number of result sources (one per RS slot).
- `NUM_LANES`, 3: CDB lanes broadcast per cycle.
- `TAG_W`, 4: ROB index width.
- `DATA_W`, 32: result value width.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  branch-mispredict flush; same effect as `rst` on all state.
- `src_valid`  in  `NUM_SRC`  source i presents a result this cycle.
- `src_tag`  in  `NUM_SRC`×`TAG_W`  ROB index of source i's result.
- `src_value`  in  `NUM_SRC`×`DATA_W`  result value of source i.
- `src_ready`  out  `NUM_SRC`  source i may present a result this cycle.
- `cdb_valid`  out  `NUM_LANES`  lane l carries a result.
- `cdb_tag`  out  `NUM_LANES`×`TAG_W`  lane l ROB index.
- `cdb_value`  out  `NUM_LANES`×`DATA_W`  lane l value.
- `overflow`  out  1  sticky: a source wrote while not ready.

## Operation
- Per source: one hold register {valid, tag, value}. `src_ready[i] = ~hold_valid[i]` (combinational from state only).
- Capture: at a clock edge with `src_valid[i] & src_ready[i]`, hold i loads tag/value and sets valid.
- Protocol violation: `src_valid[i]` while `src_ready[i]` is low → input dropped, hold unchanged, `overflow` set until reset/flush.
- Arbitration (combinational on hold state): scan indices `ptr, ptr+1, …` modulo `NUM_SRC`; grant the first up to `NUM_LANES` holds with valid set, lane 0 receives the first grant, lane 1 the second, and so on.
- On the edge: granted holds clear; lane registers load granted tag/value with `cdb_valid` set; ungranted lanes load `cdb_valid=0`, tag/value 0.
- Pointer: if any grant, `ptr` ← (index of last granted source + 1) mod `NUM_SRC`; else unchanged.
- A hold cleared by grant and a new `src_valid` for that source cannot coincide, because ready was low; a new result is accepted on the following cycle.
- Reset/flush: all holds invalid, all lane outputs 0, `ptr`=0, `overflow`=0. Flush overrides capture and grant in the same cycle. Results in flight are discarded.

## Timing
- Reset values: `cdb_valid`=0, `cdb_tag`=0, `cdb_value`=0, `overflow`=0, `src_ready`=all 1.
- Latency without contention: `src_valid` sampled at edge E → `cdb_valid` high during the cycle after edge E+1, for exactly 1 cycle.
- `cdb_*` are registered; every lane is valid for one cycle per grant. Each tag appears on at most one lane per cycle.
- Per-source throughput: one result every 2 cycles minimum.
- Contention: with k pending holds > `NUM_LANES`, excess results wait; each wait adds ≥1 cycle. Worst-case wait is ⌈`NUM_SRC`/`NUM_LANES`⌉ grant cycles.
- Pointer wrap: after a grant to source `NUM_SRC-1`, `ptr`=0.

## Test plan
- Single result: after reset, source 2 sends tag 5, value 0xDEADBEEF → two edges later lane 0 valid, tag 5, value 0xDEADBEEF for 1 cycle. `src_ready[2]` is low for exactly 1 cycle. `ptr`=3.
- Full contention: all 8 sources valid in one cycle with tags 0–7, `ptr`=0 → lanes carry {0,1,2}, then {3,4,5}, then {6,7,–} on consecutive cycles. Third cycle has lane 2 invalid; final `ptr`=0.
- Fairness: `ptr`=6, sources 0, 1, 6, 7 and 3 pending → grants in order 6, 7, 0 on lanes 0–2, then 1 and 3 next cycle.
- Violation: source 4 holds tag 9, then presents tag 10 while not ready → tag 10 never appears on the CDB, tag 9 broadcast once, `overflow`=1 until reset.
- Flush mid-operation: 5 holds pending, flush asserted together with a new `src_valid[0]` → next cycle all lanes invalid, all `src_ready`=1, nothing later broadcast.
- Reset mid-broadcast: `rst` during a cycle with 3 granted holds → lanes read 0 after the edge, `ptr`=0, `overflow`=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one hold register per result source, round-robin
// selection of up to NUM_LANES pending results into registered CDB lanes.

module cdb_arbiter_src #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              grant,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_value,
    output logic              valid,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] value
);
    logic              valid_d, valid_q;
    logic [TAG_W-1:0]  tag_d, tag_q;
    logic [DATA_W-1:0] value_d, value_q;

    // load only happens while empty and grant only while full, so they never overlap
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        value_d = value_q;
        if (clr) begin
            valid_d = 1'b0;
            tag_d   = '0;
            value_d = '0;
        end else if (load) begin
            valid_d = 1'b1;
            tag_d   = in_tag;
            value_d = in_value;
        end else if (grant) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        value_q <= value_d;
    end

    assign valid = valid_q;
    assign tag   = tag_q;
    assign value = value_q;
endmodule

module cdb_arbiter #(
    parameter int NUM_SRC   = 8,
    parameter int NUM_LANES = 3,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [NUM_SRC-1:0]                   src_valid,
    input  logic [NUM_SRC-1:0][TAG_W-1:0]        src_tag,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]       src_value,
    output logic [NUM_SRC-1:0]                   src_ready,
    output logic [NUM_LANES-1:0]                 cdb_valid,
    output logic [NUM_LANES-1:0][TAG_W-1:0]      cdb_tag,
    output logic [NUM_LANES-1:0][DATA_W-1:0]     cdb_value,
    output logic                                 overflow
);
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                               clr;
    logic [NUM_SRC-1:0]                 hold_valid;
    logic [NUM_SRC-1:0][TAG_W-1:0]      hold_tag;
    logic [NUM_SRC-1:0][DATA_W-1:0]     hold_value;
    logic [NUM_SRC-1:0]                 load;
    logic [NUM_SRC-1:0]                 grant;

    logic [SRC_W-1:0]                   ptr_d, ptr_q;
    logic                               overflow_d, overflow_q;
    logic [NUM_LANES-1:0]               cdb_valid_d, cdb_valid_q;
    logic [NUM_LANES-1:0][TAG_W-1:0]    cdb_tag_d, cdb_tag_q;
    logic [NUM_LANES-1:0][DATA_W-1:0]   cdb_value_d, cdb_value_q;

    assign clr       = rst | flush;
    assign src_ready = ~hold_valid;
    assign load      = src_valid & ~hold_valid;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_arbiter_src #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_src (
            .clk      (clk),
            .clr      (clr),
            .load     (load[i]),
            .grant    (grant[i]),
            .in_tag   (src_tag[i]),
            .in_value (src_value[i]),
            .valid    (hold_valid[i]),
            .tag      (hold_tag[i]),
            .value    (hold_value[i])
        );
    end

    // Rotating scan from ptr; the n-th pending hold found goes to lane n.
    always_comb begin
        int idx;
        int n_grant;
        logic [SRC_W-1:0]  sidx;
        logic [LANE_W-1:0] lidx;
        grant       = '0;
        cdb_valid_d = '0;
        cdb_tag_d   = '0;
        cdb_value_d = '0;
        ptr_d       = ptr_q;
        n_grant     = 0;
        idx         = 0;
        sidx        = '0;
        lidx        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            sidx = SRC_W'(idx);
            if (hold_valid[sidx] && (n_grant < NUM_LANES)) begin
                lidx               = LANE_W'(n_grant);
                grant[sidx]        = 1'b1;
                cdb_valid_d[lidx]  = 1'b1;
                cdb_tag_d[lidx]    = hold_tag[sidx];
                cdb_value_d[lidx]  = hold_value[sidx];
                ptr_d              = (idx == NUM_SRC - 1) ? '0 : SRC_W'(idx + 1);
                n_grant            = n_grant + 1;
            end
        end
        if (clr) begin
            cdb_valid_d = '0;
            cdb_tag_d   = '0;
            cdb_value_d = '0;
            ptr_d       = '0;
        end
    end

    // A write into a full hold is dropped; remember it until reset/flush.
    always_comb begin
        overflow_d = overflow_q | (|(src_valid & hold_valid));
        if (clr) overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        ptr_q       <= ptr_d;
        overflow_q  <= overflow_d;
        cdb_valid_q <= cdb_valid_d;
        cdb_tag_q   <= cdb_tag_d;
        cdb_value_q <= cdb_value_d;
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed plus randomized checks of cdb_arbiter against a queue-based model
// of the hold/round-robin/broadcast rules.

module tb_cdb_arbiter;
    localparam int NS = 8;
    localparam int NL = 3;
    localparam int TW = 4;
    localparam int DW = 32;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [NS-1:0]            src_valid;
    logic [NS-1:0][TW-1:0]    src_tag;
    logic [NS-1:0][DW-1:0]    src_value;
    logic [NS-1:0]            src_ready;
    logic [NL-1:0]            cdb_valid;
    logic [NL-1:0][TW-1:0]    cdb_tag;
    logic [NL-1:0][DW-1:0]    cdb_value;
    logic                     overflow;

    cdb_arbiter #(.NUM_SRC(NS), .NUM_LANES(NL), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_tag   (src_tag),
        .src_value (src_value),
        .src_ready (src_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit                    m_hv [NS];
    logic [TW-1:0]         m_tag[NS];
    logic [DW-1:0]         m_val[NS];
    int                    m_ptr;
    bit                    m_ovf;
    logic [NL-1:0]         e_valid;
    logic [NL-1:0][TW-1:0] e_tag;
    logic [NL-1:0][DW-1:0] e_value;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
        src_tag[i]   = t;
        src_value[i] = v;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_hv[i] = 0; m_tag[i] = '0; m_val[i] = '0;
        end
        m_ptr = 0;
        m_ovf = 0;
    endtask

    task automatic step(input logic [NS-1:0] v, input logic r, input logic f);
        logic [NS-1:0] exp_rdy;
        bit            old_hv[NS];
        int            g[$];
        src_valid = v;
        rst       = r;
        flush     = f;
        for (int i = 0; i < NS; i++) exp_rdy[i] = ~m_hv[i];
        chk("src_ready", 128'(src_ready), 128'(exp_rdy));
        e_valid = '0; e_tag = '0; e_value = '0;
        if (r || f) begin
            model_clear();
        end else begin
            for (int k = 0; k < NS; k++) begin
                int i = (m_ptr + k) % NS;
                if (m_hv[i] && g.size() < NL) g.push_back(i);
            end
            for (int l = 0; l < g.size(); l++) begin
                e_valid[l] = 1'b1;
                e_tag[l]   = m_tag[g[l]];
                e_value[l] = m_val[g[l]];
            end
            if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NS;
            old_hv = m_hv;
            foreach (g[n]) m_hv[g[n]] = 0;
            for (int i = 0; i < NS; i++) begin
                if (v[i]) begin
                    if (old_hv[i]) m_ovf = 1;
                    else begin
                        m_hv[i]  = 1;
                        m_tag[i] = src_tag[i];
                        m_val[i] = src_value[i];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", 128'(cdb_valid), 128'(e_valid));
        chk("cdb_tag",   128'(cdb_tag),   128'(e_tag));
        chk("cdb_value", 128'(cdb_value), 128'(e_value));
        chk("overflow",  128'(overflow),  128'(m_ovf));
    endtask

    initial begin
        src_valid = '0; src_tag = '0; src_value = '0;
        rst = 1'b1; flush = 1'b0;
        model_clear();
        #1;
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);

        // single result, source 2
        set_src(2, 4'd5, 32'hDEADBEEF);
        step(8'h04, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);

        // full contention from ptr 0
        step('0, 1'b1, 1'b0);
        for (int i = 0; i < NS; i++) set_src(i, TW'(i), 32'h1000_0000 + 32'(i));
        step(8'hFF, 1'b0, 1'b0);
        repeat (4) step('0, 1'b0, 1'b0);

        // fairness: drive ptr to 6, then sources 0,1,3,6,7 pending
        step(8'h3F, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        for (int i = 0; i < NS; i++) set_src(i, TW'(i + 8), 32'hA000_0000 + 32'(i));
        step(8'hCB, 1'b0, 1'b0);
        repeat (3) step('0, 1'b0, 1'b0);

        // violation on source 4
        set_src(4, 4'd9, 32'h0000_0009);
        step(8'h10, 1'b0, 1'b0);
        set_src(4, 4'd10, 32'h0000_000A);
        step(8'h10, 1'b0, 1'b0);
        repeat (3) step('0, 1'b0, 1'b0);

        // reset while three holds are being granted
        step(8'h07, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);

        // flush with five pending and a fresh source 0 result
        step(8'h1F, 1'b0, 1'b0);
        set_src(0, 4'd3, 32'h3333_3333);
        step(8'h01, 1'b0, 1'b1);
        repeat (3) step('0, 1'b0, 1'b0);

        // randomized traffic with occasional violations, flushes and resets
        for (int n = 0; n < 400; n++) begin
            logic [NS-1:0] v;
            logic r, f;
            for (int i = 0; i < NS; i++) begin
                set_src(i, TW'($urandom), DW'($urandom));
                if (!m_hv[i]) v[i] = ($urandom_range(0, 99) < 50);
                else          v[i] = ($urandom_range(0, 99) < 3);
            end
            r = ($urandom_range(0, 99) < 1);
            f = ($urandom_range(0, 99) < 2);
            step(v, r, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
